// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single unified memory port between instruction fetch (IF) and
//   the load/store (LS) path. Each access is a req/ack handshake on the memory
//   side. Load data is lane-selected and sign/zero extended before it goes
//   back to the core. stall freezes the PC and write-back while any request
//   is outstanding.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to build an ack timeout. When
//   TIMEOUT_CYCLES mem_req cycles pass without mem_ack, the access is aborted
//   and bus_err pulses with the owner's valid. Without the macro, bus_err is
//   constant 0 and the block waits for mem_ack indefinitely.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   if_*              fetch request (held until if_valid), instruction return
//   ls_*              load/store request (held until ls_valid), size/sign
//                     control, store data, extended load data, misalign flag
//   mem_*             registered memory request side, word addressed, with
//                     byte enables and lane-replicated write data
//   bus_err           timeout pulse, coincident with the owning valid
//   stall             (if_req & ~if_valid) | (ls_req & ~ls_valid)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_r_w,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_valid,
    output logic              ls_misaligned,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_w,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err,
    output logic              stall
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, DONE} state_t;

    state_t     state, state_nxt;
    logic       mask_if, mask_ls;   // requester served by the previous transaction
    logic [1:0] r_size, r_lo;       // latched LS size and byte offset
    logic       r_uns, r_rw;
    logic       ls_bad, grant_ls, grant_if, busy, tmo_hit;

    // Fetch addresses are word aligned; the low bits carry no information.
    logic unused_bits;
    assign unused_bits = &{1'b0, if_addr[1:0]};

    // ----------------------------------------------------------------------
    // Helpers
    // ----------------------------------------------------------------------
    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend.
    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic uns);
        logic [31:0] sh;
        sh = d >> {lo, 3'b000};
        case (sz)
            2'd0:    return {{24{sh[7] & ~uns}}, sh[7:0]};
            2'd1:    return {{16{sh[15] & ~uns}}, sh[15:0]};
            default: return d;
        endcase
    endfunction

    // ----------------------------------------------------------------------
    // Arbitration
    // ----------------------------------------------------------------------
    // Size 3 is not a legal encoding and is rejected like a misalignment.
    assign ls_bad = (ls_size == 2'd3) ||
                    ((ls_size == 2'd1) && ls_addr[0]) ||
                    ((ls_size == 2'd2) && (ls_addr[1:0] != 2'b00));

    // LS wins: it belongs to the older instruction in the pipe.
    assign grant_ls = (state == IDLE) && ls_req && !mask_ls;
    assign grant_if = (state == IDLE) && if_req && !mask_if && !grant_ls;
    assign busy     = (state == IF_BUSY) || (state == LS_BUSY);

    assign stall = (if_req & ~if_valid) | (ls_req & ~ls_valid);

    // ----------------------------------------------------------------------
    // Ack timeout
    // ----------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Cleared while idle, so every grant starts from zero.
    always_ff @(posedge clock) begin
        if (reset || (state == IDLE))
            tmo_cnt <= '0;
        else if (busy)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = busy && !mem_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // ----------------------------------------------------------------------
    // FSM
    // ----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mask_if <= 1'b0;
            mask_ls <= 1'b0;
        end else begin
            state <= state_nxt;
            // The mask is armed on entry to DONE and lives through exactly
            // one IDLE cycle, so a requester still holding req while its
            // valid is consumed cannot be re-served.
            if (state_nxt == DONE) begin
                mask_if <= (state == IF_BUSY);
                mask_ls <= (state != IF_BUSY);
            end else if (state == IDLE) begin
                mask_if <= 1'b0;
                mask_ls <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ls)
                    state_nxt = ls_bad ? DONE : LS_BUSY;
                else if (grant_if)
                    state_nxt = IF_BUSY;
            end
            IF_BUSY,
            LS_BUSY: begin
                if (mem_ack || tmo_hit)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------------------
    // Registered memory side and completion outputs
    // ----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_r_w       <= 1'b0;
            mem_be        <= 4'h0;
            mem_wdata     <= 32'h0;
            if_valid      <= 1'b0;
            if_rdata      <= 32'h0;
            ls_valid      <= 1'b0;
            ls_rdata      <= 32'h0;
            ls_misaligned <= 1'b0;
            bus_err       <= 1'b0;
            r_size        <= 2'd0;
            r_lo          <= 2'd0;
            r_uns         <= 1'b0;
            r_rw          <= 1'b0;
        end else begin
            if_valid      <= 1'b0;
            ls_valid      <= 1'b0;
            ls_misaligned <= 1'b0;
            bus_err       <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        r_size <= ls_size;
                        r_lo   <= ls_addr[1:0];
                        r_uns  <= ls_unsigned;
                        r_rw   <= ls_r_w;
                        if (ls_bad) begin
                            // Rejected before touching memory; report in DONE.
                            ls_valid      <= 1'b1;
                            ls_misaligned <= 1'b1;
                            ls_rdata      <= 32'h0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                            mem_r_w   <= ls_r_w;
                            mem_be    <= be_of(ls_size, ls_addr[1:0]);
                            mem_wdata <= rep_of(ls_size, ls_wdata);
                        end
                    end else if (grant_if) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                        mem_r_w   <= 1'b1;
                        mem_be    <= 4'hF;
                        mem_wdata <= 32'h0;
                    end
                end

                IF_BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= 32'h0;
                        bus_err  <= 1'b1;
                    end
                end

                LS_BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        ls_valid <= 1'b1;
                        ls_rdata <= r_rw ? fmt_load(mem_rdata, r_size, r_lo, r_uns) : 32'h0;
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        ls_valid <= 1'b1;
                        ls_rdata <= 32'h0;
                        bus_err  <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store path driven by decode's mem_r_w, mem_access_size and mem_load_unsigned.
- Sequences each access with a req/ack handshake and formats load data (lane select plus sign/zero extension).
- Asserts stall to freeze the PC and register write-back while any access is outstanding.
- Sits between the core datapath and the memory model/bus.

Parameters:
ADDR_W, 32, address width
TIMEOUT_CYCLES, 255, cycles without mem_ack before abort (optional feature only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address, word aligned
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
ls_req  in  1  load/store request, held until ls_valid
ls_r_w  in  1  1=load, 0=store (decode mem_r_w)
ls_size  in  2  0=byte, 1=half, 2=word (decode mem_access_size)
ls_unsigned  in  1  zero-extend load (decode mem_load_unsigned)
ls_addr  in  ADDR_W  data address
ls_wdata  in  32  store data, right-aligned
ls_rdata  out  32  extended load data
ls_valid  out  1  one-cycle load/store completion pulse
ls_misaligned  out  1  pulses with ls_valid on a misaligned/illegal access
mem_req  out  1  memory request
mem_addr  out  ADDR_W  word address (low 2 bits forced 0)
mem_r_w  out  1  1=read, 0=write
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  access complete
bus_err  out  1  timeout pulse (optional feature; tied 0 otherwise)
stall  out  1  combinational: (if_req & ~if_valid) | (ls_req & ~ls_valid)

Behaviour:
- States: IDLE, IF_BUSY, LS_BUSY, DONE.
- Reset: state=IDLE and last-served mask cleared. All registered outputs are 0: mem_req, mem_r_w, mem_be, mem_addr, mem_wdata, if_valid, ls_valid, ls_misaligned, bus_err, if_rdata, ls_rdata.
- Reset mid-access drops mem_req the next cycle, and no valid pulses are issued.
- IDLE arbitration: ls_req has priority over if_req, because the load/store belongs to the older instruction. The requester served in the immediately preceding transaction is masked for that one IDLE cycle, so a still-high req is never re-served.
- Grant: on the granting edge, latch addr, size, r_w, unsigned and wdata, then enter *_BUSY. mem_req is registered and high from the next cycle, held with stable outputs until mem_ack is sampled high.
- Misaligned check, applied before any memory access:
  - half access with addr[0]=1, word access with addr[1:0]!=0, or ls_size=3.
  - Goes IDLE->DONE with no mem_req.
  - ls_valid=1 and ls_misaligned=1 next cycle, ls_rdata=0.
- mem_be:
  - byte: 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - IF reads always use 4'b1111.
- mem_wdata: byte replicated x4, half replicated x2, word unchanged.
- Completion: mem_ack sampled in BUSY causes a registered capture. mem_req drops and the matching valid pulses in the following cycle (DONE), then the block returns to IDLE.
- Load extension: select lane by addr[1:0]. Sign-extend from bit 7/15 unless ls_unsigned. Stores return ls_rdata=0.
- Minimum latency (ack in first mem_req cycle): request cycle N, mem_req at N+1, valid at N+2, next grant evaluated at N+3.
- Simultaneous if_req and ls_req: LS is served first, then IF (unmasked) on the next IDLE.
- mem_ack outside a BUSY state is ignored.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs while mem_req is high.
  - On reaching TIMEOUT_CYCLES without mem_ack: drop mem_req, pulse the owning valid together with bus_err=1 (rdata=0), return to IDLE.
  - The counter clears on every grant.
- MEM_ARB_TIMEOUT_EN undefined: no counter is built, bus_err is constant 0, and the block waits for mem_ack indefinitely.

Test Plan:
- if_req=1, if_addr=0x100, mem_ack same cycle as mem_req, mem_rdata=0x00500093 -> mem_be=4'hF, if_valid at cycle N+2, if_rdata=0x00500093, stall low after pulse.
- if_req and ls_req both high, ls load word 0x200 -> LS memory access first, IF next; no duplicate LS access while ls_req is held during its valid cycle.
- Load byte signed at 0x203, mem_rdata=0x80FF0000 -> ls_rdata=0xFFFFFF80; same access with ls_unsigned=1 -> 0x00000080.
- Store half 0xABCD to 0x102 -> mem_r_w=0, mem_be=4'b1100, mem_wdata=0xABCDABCD, ls_valid pulse with ls_rdata=0.
- Load word at 0x101 -> no mem_req, ls_valid=1 and ls_misaligned=1 exactly one cycle.
- Reset asserted while mem_req waits for ack -> mem_req=0 next cycle, no valid; with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, withholding ack -> bus_err and if_valid pulse after 4 mem_req cycles.
